// File: rtl/dcache_writeback.sv
// Dirty-line write-back engine: reads one 32-byte line from the eight data RAM
// banks in a single access and drains it as an 8-beat AXI4 INCR write burst.
module dcache_writeback (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wb_req,
  input  logic [19:0]  wb_tag,
  input  logic [6:0]   wb_index,
  output logic         wb_ready,
  output logic         wb_done,
  output logic         ram_en,
  output logic [31:0]  ram_addr,
  input  logic [255:0] ram_rdata,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LATCH = 3'd2,
    S_AW    = 3'd3,
    S_W     = 3'd4,
    S_B     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [19:0] r_tag;
  logic [6:0]  r_index;
  logic [2:0]  r_cnt;
  logic        r_done;
  logic [31:0] r_line [8];

  logic        w_capture;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic [31:0] w_line_addr;
  logic        w_unused;

  // Any B response completes the write-back, so its id and status are dropped.
  assign w_unused    = ^{bid, bresp};
  assign w_line_addr = {r_tag, r_index, 5'b0};

  assign w_capture = (r_state == S_IDLE) && wb_req;
  assign w_aw_hs   = (r_state == S_AW) && awready;
  assign w_w_hs    = (r_state == S_W) && wready;
  assign w_b_hs    = (r_state == S_B) && bvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_tag   <= '0;
      r_index <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_b_hs;
      if (w_capture) begin
        r_tag   <= wb_tag;
        r_index <= wb_index;
      end
      // The counter wraps 7->0 on the last beat, leaving it clean for the next line.
      if (w_aw_hs) begin
        r_cnt <= '0;
      end else if (w_w_hs) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  // Line buffer holds data only; it is always rewritten before it is read.
  always_ff @(posedge clk) begin
    if (r_state == S_LATCH) begin
      for (int i = 0; i < 8; i++) begin
        r_line[i] <= ram_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (wb_req) w_state_nxt = S_RD;
      S_RD:    w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_AW;
      S_AW:    if (awready) w_state_nxt = S_W;
      S_W:     if (wready && (r_cnt == 3'd7)) w_state_nxt = S_B;
      S_B:     if (bvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wb_ready = 1'b0;
    ram_en   = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    wdata    = '0;
    bready   = 1'b0;
    case (r_state)
      S_IDLE: wb_ready = 1'b1;
      S_RD:   ram_en   = 1'b1;
      S_AW:   awvalid  = 1'b1;
      S_W: begin
        wvalid = 1'b1;
        wdata  = r_line[r_cnt];
        wlast  = (r_cnt == 3'd7);
      end
      S_B:     bready = 1'b1;
      default: wb_ready = 1'b0;
    endcase
  end

  assign wb_done  = r_done;
  assign ram_addr = w_line_addr;
  assign awaddr   = w_line_addr;
  assign awid     = 4'd1;
  assign awlen    = 8'd7;
  assign awsize   = 3'd2;
  assign awburst  = 2'b01;
  assign awlock   = 2'b00;
  assign awcache  = 4'd0;
  assign awprot   = 3'd0;
  assign wid      = 4'd1;
  assign wstrb    = 4'hF;

endmodule
